// File: rtl/mem_pipe_reg.sv
// Memory-stage pipeline register with a two-entry (main + skid) buffer.
// Captures SRAM read data alongside each entry and extracts/extends load
// data from the head entry, driving both writeback and forwarding buses.
module mem_pipe_reg #(
    parameter int unsigned BUS_WD = 50,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BUS_WD-1:0] in_bus,
    input  logic              in_ld,
    input  logic [1:0]        in_ld_size,
    input  logic              in_ld_uns,
    input  logic [2:0]        in_ld_off,
    input  logic              in_rf_we,
    input  logic [4:0]        in_rf_waddr,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BUS_WD-1:0] out_bus,
    output logic              out_rf_we,
    output logic [4:0]        out_rf_waddr,
    output logic [DATA_W-1:0] out_wdata,
    output logic              fwd_valid,
    output logic              fwd_rf_we,
    output logic [4:0]        fwd_rf_waddr,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  hold_cnt
);

    typedef struct packed {
        logic [BUS_WD-1:0] bus;
        logic              ld;
        logic [1:0]        ld_size;
        logic              ld_uns;
        logic [2:0]        ld_off;
        logic              rf_we;
        logic [4:0]        rf_waddr;
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] rdata;
    } entry_t;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;

    logic main_valid_q, main_valid_d;
    logic skid_valid_q, skid_valid_d;
    logic accept, pop;

    logic [CNT_W-1:0] hold_cnt_q;
    logic [DATA_W-1:0] wdata;

    // Bundle the incoming fields, including the raw SRAM word for this entry.
    always_comb begin
        in_entry          = '0;
        in_entry.bus      = in_bus;
        in_entry.ld       = in_ld;
        in_entry.ld_size  = in_ld_size;
        in_entry.ld_uns   = in_ld_uns;
        in_entry.ld_off   = in_ld_off;
        in_entry.rf_we    = in_rf_we;
        in_entry.rf_waddr = in_rf_waddr;
        in_entry.result   = in_result;
        in_entry.rdata    = sram_rdata;
    end

    // in_ready comes purely from the skid valid register.
    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready && !flush;
    assign pop      = main_valid_q && out_ready;

    // Next-state for the main/skid slots; flush overrides accept and pop.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (pop) begin
            if (skid_valid_q) begin
                // Skid advances to head; a new entry (if any) refills skid.
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = accept;
                if (accept) begin
                    skid_d = in_entry;
                end
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_d = in_entry;
                end
            end
        end else if (accept) begin
            if (main_valid_q) begin
                skid_d       = in_entry;
                skid_valid_d = 1'b1;
            end else begin
                main_d       = in_entry;
                main_valid_d = 1'b1;
            end
        end
    end

    // Valid bits: cleared asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // Payload registers are don't-care while invalid, so they carry no reset.
    always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

    // Stall counter: counts head-stalled cycles, saturating, untouched by flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_q <= '0;
        end else if (main_valid_q && !out_ready && (hold_cnt_q != '1)) begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
        end
    end

    // Load lane select and extension from the head entry's captured SRAM word.
    always_comb begin
        logic [63:0] raw64;
        logic [63:0] shifted;
        logic [63:0] ext64;
        logic [2:0]  off_eff;
        logic [7:0]  lane8;
        logic [15:0] lane16;
        logic [31:0] lane32;
        logic        sx;

        raw64   = 64'(main_q.rdata);
        off_eff = main_q.ld_off;
        // A 32-bit data word has no upper half to select.
        if (DATA_W == 32) begin
            off_eff[2] = 1'b0;
        end
        sx      = !main_q.ld_uns;
        shifted = '0;
        lane8   = '0;
        lane16  = '0;
        lane32  = '0;
        ext64   = '0;
        case (main_q.ld_size)
            2'd0: begin
                shifted = raw64 >> {off_eff, 3'b000};
                lane8   = shifted[7:0];
                ext64   = {{56{sx & lane8[7]}}, lane8};
            end
            2'd1: begin
                shifted = raw64 >> {off_eff[2:1], 4'b0000};
                lane16  = shifted[15:0];
                ext64   = {{48{sx & lane16[15]}}, lane16};
            end
            2'd2: begin
                shifted = raw64 >> {off_eff[2], 5'b00000};
                lane32  = shifted[31:0];
                ext64   = {{32{sx & lane32[31]}}, lane32};
            end
            default: begin
                if (DATA_W == 64) begin
                    ext64 = raw64;
                end else begin
                    // Doubleword on a 32-bit path degenerates to the full word.
                    lane32 = raw64[31:0];
                    ext64  = {{32{sx & lane32[31]}}, lane32};
                end
            end
        endcase
        wdata = main_q.ld ? ext64[DATA_W-1:0] : main_q.result;
    end

    // Head outputs; write enables are masked by the head valid bit.
    always_comb begin
        out_valid    = main_valid_q;
        out_bus      = main_q.bus;
        out_rf_we    = main_valid_q && main_q.rf_we;
        out_rf_waddr = main_q.rf_waddr;
        out_wdata    = wdata;
        fwd_valid    = main_valid_q;
        fwd_rf_we    = main_valid_q && main_q.rf_we;
        fwd_rf_waddr = main_q.rf_waddr;
        fwd_data     = wdata;
        hold_cnt     = hold_cnt_q;
    end

endmodule

// File: tb/tb_mem_pipe_reg.sv
// Self-checking bench for mem_pipe_reg: directed scenarios followed by random
// traffic, compared against a queue-based reference model.
module tb_mem_pipe_reg;

    localparam int unsigned BW = 50;

    logic          clk, rst, flush, in_valid, out_ready;
    logic [BW-1:0] in_bus;
    logic          in_ld, in_ld_uns, in_rf_we;
    logic [1:0]    in_ld_size;
    logic [2:0]    in_ld_off;
    logic [4:0]    in_rf_waddr;
    logic [63:0]   in_result, sram_rdata;

    logic          in_ready, out_valid, out_rf_we, fwd_valid, fwd_rf_we;
    logic [BW-1:0] out_bus;
    logic [4:0]    out_rf_waddr, fwd_rf_waddr;
    logic [63:0]   out_wdata, fwd_data;
    logic [3:0]    hold_cnt;

    logic          in_ready32, out_valid32, out_rf_we32, fwd_valid32, fwd_rf_we32;
    logic [BW-1:0] out_bus32;
    logic [4:0]    out_rf_waddr32, fwd_rf_waddr32;
    logic [31:0]   out_wdata32, fwd_data32;
    logic [3:0]    hold_cnt32;

    mem_pipe_reg #(.BUS_WD(BW), .DATA_W(64), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_bus(in_bus), .in_ld(in_ld), .in_ld_size(in_ld_size), .in_ld_uns(in_ld_uns),
        .in_ld_off(in_ld_off), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
        .in_result(in_result), .sram_rdata(sram_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_bus(out_bus), .out_rf_we(out_rf_we),
        .out_rf_waddr(out_rf_waddr), .out_wdata(out_wdata), .fwd_valid(fwd_valid),
        .fwd_rf_we(fwd_rf_we), .fwd_rf_waddr(fwd_rf_waddr), .fwd_data(fwd_data),
        .hold_cnt(hold_cnt)
    );

    mem_pipe_reg #(.BUS_WD(BW), .DATA_W(32), .CNT_W(4)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .in_bus(in_bus), .in_ld(in_ld), .in_ld_size(in_ld_size), .in_ld_uns(in_ld_uns),
        .in_ld_off(in_ld_off), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
        .in_result(in_result[31:0]), .sram_rdata(sram_rdata[31:0]),
        .out_valid(out_valid32), .out_ready(out_ready), .out_bus(out_bus32),
        .out_rf_we(out_rf_we32), .out_rf_waddr(out_rf_waddr32), .out_wdata(out_wdata32),
        .fwd_valid(fwd_valid32), .fwd_rf_we(fwd_rf_we32), .fwd_rf_waddr(fwd_rf_waddr32),
        .fwd_data(fwd_data32), .hold_cnt(hold_cnt32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] bus;
        logic          ld;
        logic [1:0]    size;
        logic          uns;
        logic [2:0]    off;
        logic          we;
        logic [4:0]    waddr;
        logic [63:0]   result;
        logic [63:0]   rdata;
    } ent_t;

    ent_t q[$];
    int   hold_m;
    int   nvec;
    int   nerr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Expected writeback value from the load rules, for a data path of dw bits.
    function automatic logic [63:0] exp_wdata(input ent_t e, input int dw);
        int          nbytes;
        int          start;
        logic [63:0] v;
        logic [63:0] mask;
        if (!e.ld) return (dw == 64) ? e.result : {32'h0, e.result[31:0]};
        nbytes = 1 << e.size;
        if (nbytes > dw / 8) nbytes = dw / 8;
        start = int'(e.off) % (dw / 8);
        start = start - (start % nbytes);
        v = e.rdata >> (start * 8);
        if (nbytes < 8) begin
            mask = (64'h1 << (nbytes * 8)) - 64'h1;
            v = v & mask;
            if (!e.uns && v[nbytes*8-1]) v = v | ~mask;
        end
        if (dw == 32) v = {32'h0, v[31:0]};
        return v;
    endfunction

    function automatic ent_t cur_in();
        ent_t e;
        e.bus = in_bus; e.ld = in_ld; e.size = in_ld_size; e.uns = in_ld_uns;
        e.off = in_ld_off; e.we = in_rf_we; e.waddr = in_rf_waddr;
        e.result = in_result; e.rdata = sram_rdata;
        return e;
    endfunction

    task automatic check_outputs();
        logic v;
        v = (q.size() > 0);
        chk("in_ready", {63'h0, in_ready}, {63'h0, q.size() < 2});
        chk("out_valid", {63'h0, out_valid}, {63'h0, v});
        chk("fwd_valid", {63'h0, fwd_valid}, {63'h0, v});
        chk("hold_cnt", {60'h0, hold_cnt}, 64'(hold_m));
        chk("out_valid32", {63'h0, out_valid32}, {63'h0, v});
        if (v) begin
            chk("out_rf_we", {63'h0, out_rf_we}, {63'h0, q[0].we});
            chk("fwd_rf_we", {63'h0, fwd_rf_we}, {63'h0, q[0].we});
            chk("out_rf_waddr", {59'h0, out_rf_waddr}, {59'h0, q[0].waddr});
            chk("fwd_rf_waddr", {59'h0, fwd_rf_waddr}, {59'h0, q[0].waddr});
            chk("out_bus", {14'h0, out_bus}, {14'h0, q[0].bus});
            chk("out_wdata", out_wdata, exp_wdata(q[0], 64));
            chk("fwd_data", fwd_data, exp_wdata(q[0], 64));
            chk("out_wdata32", {32'h0, out_wdata32}, exp_wdata(q[0], 32));
        end else begin
            chk("out_rf_we_idle", {63'h0, out_rf_we}, 64'h0);
            chk("fwd_rf_we_idle", {63'h0, fwd_rf_we}, 64'h0);
        end
    endtask

    task automatic model_edge();
        logic acc, pp;
        acc = in_valid && (q.size() < 2) && !flush;
        pp  = (q.size() > 0) && out_ready;
        if ((q.size() > 0) && !out_ready && hold_m < 15) hold_m++;
        if (flush) begin
            q.delete();
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(cur_in());
        end
    endtask

    // Called 1 time unit after a rising edge; returns 1 unit after the next one.
    task automatic cycle();
        #3;
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [4:0] wa, input logic ld,
                          input logic [1:0] sz, input logic uns, input logic [2:0] off,
                          input logic [63:0] res, input logic [63:0] rd);
        in_valid = v; in_rf_waddr = wa; in_ld = ld; in_ld_size = sz; in_ld_uns = uns;
        in_ld_off = off; in_result = res; sram_rdata = rd; in_rf_we = 1'b1;
        in_bus = {$urandom, $urandom};
    endtask

    task automatic rand_in();
        in_valid    = ($urandom % 4) != 0;
        out_ready   = ($urandom % 3) != 0;
        flush       = ($urandom % 25) == 0;
        in_bus      = {$urandom, $urandom};
        in_ld       = $urandom % 2;
        in_ld_size  = 2'($urandom);
        in_ld_uns   = $urandom % 2;
        in_ld_off   = 3'($urandom);
        in_rf_we    = $urandom % 2;
        in_rf_waddr = 5'($urandom);
        in_result   = {$urandom, $urandom};
        sram_rdata  = {$urandom, $urandom};
    endtask

    localparam logic [63:0] RD = 64'h8877_6655_4433_2211;

    initial begin
        nvec = 0; nerr = 0; hold_m = 0;
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        set_in(1'b1, 5'd9, 1'b0, 2'd0, 1'b0, 3'd0, 64'h1234, 64'h0);

        // Reset asserted with in_valid high: nothing may be accepted.
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
        chk("rst_hold_cnt", {60'h0, hold_cnt}, 64'h0);
        chk("rst_fwd_rf_we", {63'h0, fwd_rf_we}, 64'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        set_in(1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 3'd0, 64'h0, 64'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Streaming: three back-to-back entries, downstream always ready.
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            set_in(1'b1, 5'(i), 1'b0, 2'd0, 1'b0, 3'd0, 64'(i * 64'h1111), 64'h0);
            cycle();
            chk("stream_waddr", {59'h0, out_rf_waddr}, 64'(i));
        end
        set_in(1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 3'd0, 64'h0, 64'h0);
        cycle();
        cycle();

        // Async reset mid-stall with two entries held and hold_cnt at 5.
        out_ready = 1'b0;
        set_in(1'b1, 5'd4, 1'b0, 2'd0, 1'b0, 3'd0, 64'hA, 64'h0);
        cycle();
        set_in(1'b1, 5'd5, 1'b0, 2'd0, 1'b0, 3'd0, 64'hB, 64'h0);
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 10 && hold_m < 5; i++) cycle();
        chk("pre_rst_hold", {60'h0, hold_cnt}, 64'h5);
        chk("pre_rst_in_ready", {63'h0, in_ready}, 64'h0);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("arst_hold_cnt", {60'h0, hold_cnt}, 64'h0);
        chk("arst_in_ready", {63'h0, in_ready}, 64'h1);
        q.delete();
        hold_m = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cycle();

        // Backpressure: A and B accepted with a stalled head, then drained.
        out_ready = 1'b0;
        set_in(1'b1, 5'd10, 1'b0, 2'd0, 1'b0, 3'd0, 64'hAAAA, 64'h0);
        cycle();
        set_in(1'b1, 5'd11, 1'b0, 2'd0, 1'b0, 3'd0, 64'hBBBB, 64'h0);
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("bp_in_ready_full", {63'h0, in_ready}, 64'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // Directed load extraction.
        out_ready = 1'b1;
        set_in(1'b1, 5'd12, 1'b1, 2'd0, 1'b0, 3'd7, 64'h0, RD);
        cycle();
        in_valid = 1'b0;
        #2 chk("lb_off7", out_wdata, 64'hFFFF_FFFF_FFFF_FF88);
        cycle();
        set_in(1'b1, 5'd13, 1'b1, 2'd1, 1'b1, 3'd6, 64'h0, RD);
        cycle();
        in_valid = 1'b0;
        #2 chk("lhu_off6", out_wdata, 64'h8877);
        cycle();
        set_in(1'b1, 5'd14, 1'b1, 2'd2, 1'b0, 3'd4, 64'h0, RD);
        cycle();
        in_valid = 1'b0;
        #2 chk("lw_off4", out_wdata, 64'hFFFF_FFFF_8877_6655);
        cycle();
        set_in(1'b1, 5'd15, 1'b1, 2'd3, 1'b0, 3'd0, 64'h0, RD);
        cycle();
        in_valid = 1'b0;
        #2 chk("ld_raw", out_wdata, RD);
        cycle();

        // Flush with both slots full and a new entry offered the same cycle.
        out_ready = 1'b0;
        set_in(1'b1, 5'd20, 1'b0, 2'd0, 1'b0, 3'd0, 64'h20, 64'h0);
        cycle();
        set_in(1'b1, 5'd21, 1'b0, 2'd0, 1'b0, 3'd0, 64'h21, 64'h0);
        cycle();
        flush = 1'b1;
        set_in(1'b1, 5'd22, 1'b0, 2'd0, 1'b0, 3'd0, 64'h22, 64'h0);
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        #2;
        chk("flush_out_valid", {63'h0, out_valid}, 64'h0);
        chk("flush_fwd_rf_we", {63'h0, fwd_rf_we}, 64'h0);
        chk("flush_in_ready", {63'h0, in_ready}, 64'h1);
        cycle();

        // Saturation: 20 stalled cycles on a 4-bit counter.
        out_ready = 1'b0;
        set_in(1'b1, 5'd23, 1'b0, 2'd0, 1'b0, 3'd0, 64'h23, 64'h0);
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        chk("hold_sat", {60'h0, hold_cnt}, 64'd15);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("hold_kept_by_flush", {60'h0, hold_cnt}, 64'd15);

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            rand_in();
            cycle();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
